// File: rtl/condicionador_sensores.sv
// rtl/condicionador_sensores.sv - synchronizer + tick-based debouncer for the four navigation sensors
//
// Purpose: takes four raw asynchronous, bouncy sensor lines, brings each into
// the clock domain through a 2-flop synchronizer and debounces it on a shared
// sample tick, so the navigation FSM sees clean levels.
//
// Ports:
//   clock         system clock, all state on the rising edge
//   reset         synchronous active-high reset
//   head_bruto    raw front-obstacle sensor (async)
//   left_bruto    raw left-obstacle sensor (async)
//   under_bruto   raw floor sensor (async)
//   rubble_bruto  raw rubble sensor (async)
//   head/left/under/rubble  debounced levels
//   mudou         one-clock pulse when any debounced level changes
//   pronto        high once the filters have seen DEB_CYCLES ticks after reset
module condicionador_sensores #(
  parameter int DEB_CYCLES = 8,
  parameter int SAMPLE_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic head_bruto,
  input  logic left_bruto,
  input  logic under_bruto,
  input  logic rubble_bruto,
  output logic head,
  output logic left,
  output logic under,
  output logic rubble,
  output logic mudou,
  output logic pronto
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(DEB_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

  // Channel order in all vectors: bit0 head, bit1 left, bit2 under, bit3 rubble.
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    out_q, out_d;
  logic [CW-1:0] settle_q, settle_d;
  logic          mudou_q, mudou_d;
  logic          pronto_q, pronto_d;

  assign raw = {rubble_bruto, under_bruto, left_bruto, head_bruto};

  // With SAMPLE_DIV=1 the prescaler sits at 0 and PRESC_LAST is 0, so tick stays high.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    out_d    = out_q;
    settle_d = settle_q;
    for (int ch = 0; ch < 4; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (tick) begin
        if (sync2_q[ch] != out_q[ch]) begin
          // Flip only after DEB_CYCLES consecutive differing ticks; counter never passes CNT_LAST.
          if (cnt_q[ch] == CNT_LAST) begin
            out_d[ch] = sync2_q[ch];
            cnt_d[ch] = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
          end
        end else begin
          cnt_d[ch] = '0;
        end
      end
    end
    if (tick && (settle_q != SETTLE_MAX)) begin
      settle_d = settle_q + CW'(1);
    end
    // A single pulse covers any number of channels flipping on the same tick.
    mudou_d  = |(out_d ^ out_q);
    pronto_d = pronto_q | (settle_q == SETTLE_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      presc_q  <= '0;
      out_q    <= '0;
      settle_q <= '0;
      mudou_q  <= 1'b0;
      pronto_q <= 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      presc_q  <= presc_d;
      out_q    <= out_d;
      settle_q <= settle_d;
      mudou_q  <= mudou_d;
      pronto_q <= pronto_d;
      for (int ch = 0; ch < 4; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign head   = out_q[0];
  assign left   = out_q[1];
  assign under  = out_q[2];
  assign rubble = out_q[3];
  assign mudou  = mudou_q;
  assign pronto = pronto_q;

endmodule

// File: tb/tb_condicionador_sensores.sv
// tb/tb_condicionador_sensores.sv - scoreboard bench for condicionador_sensores (DEB_CYCLES=3, SAMPLE_DIV=2)
module tb_condicionador_sensores;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic head_bruto = 1'b0, left_bruto = 1'b0, under_bruto = 1'b0, rubble_bruto = 1'b0;
  logic head, left, under, rubble, mudou, pronto;

  int vectors = 0;
  int miscompares = 0;

  // Expected {head,left,under,rubble} at each mudou pulse, in order.
  logic [3:0] exp_q[$];
  logic       prev_mudou = 1'b0;

  condicionador_sensores #(.DEB_CYCLES(3), .SAMPLE_DIV(2)) dut (
    .clock(clock), .reset(reset),
    .head_bruto(head_bruto), .left_bruto(left_bruto),
    .under_bruto(under_bruto), .rubble_bruto(rubble_bruto),
    .head(head), .left(left), .under(under), .rubble(rubble),
    .mudou(mudou), .pronto(pronto)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every mudou pulse must be expected, one clock wide,
  // and coincide with the expected new output levels.
  always @(negedge clock) begin
    if (!reset && mudou) begin
      vectors++;
      if (prev_mudou) begin
        miscompares++;
        $display("FAIL mudou_width: mudou high two cycles in a row, required single-cycle pulse");
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL mudou_unexpected: outputs=%b with no pulse expected at %0t", {head, left, under, rubble}, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({head, left, under, rubble} !== e) begin
          miscompares++;
          $display("FAIL outputs_at_mudou: got %b required %b", {head, left, under, rubble}, e);
        end
      end
    end
    prev_mudou = mudou;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_raw(input logic [3:0] v);
    {head_bruto, left_bruto, under_bruto, rubble_bruto} = v;
  endtask

  task automatic wait_drain(input int bound, input string name);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step(1);
    step(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d expected mudou pulses still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_out(input logic [3:0] e, input string name);
    vectors++;
    if ({head, left, under, rubble} !== e) begin
      miscompares++;
      $display("FAIL %s: outputs got %b required %b", name, {head, left, under, rubble}, e);
    end
  endtask

  task automatic test_reset;
    int k_pronto, k_out;
    k_pronto = 0; k_out = 0;
    set_raw(4'b1111);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      vectors++;
      if ({head, left, under, rubble, mudou, pronto} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold: outputs/mudou/pronto got %b required 000000", {head, left, under, rubble, mudou, pronto});
      end
    end
    exp_q.push_back(4'b1111);
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (pronto === 1'b1 && k_pronto == 0) k_pronto = k;
      if (head === 1'b1 && k_out == 0) k_out = k;
    end
    vectors++;
    if (k_pronto != 7) begin
      miscompares++;
      $display("FAIL reset_pronto_latency: pronto rose after %0d clocks, required 7", k_pronto);
    end
    vectors++;
    if (k_out != 8) begin
      miscompares++;
      $display("FAIL reset_output_latency: outputs rose after %0d clocks, required 8", k_out);
    end
    check_out(4'b1111, "reset_settled");
    wait_drain(10, "reset");
  endtask

  task automatic test_clean_step;
    int k_out;
    k_out = 0;
    exp_q.push_back(4'b0000);
    set_raw(4'b0000);
    wait_drain(30, "clear");
    check_out(4'b0000, "clear_all");
    exp_q.push_back(4'b1000);
    head_bruto = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (head === 1'b1 && k_out == 0) k_out = k;
    end
    vectors++;
    if (k_out < 7 || k_out > 10) begin
      miscompares++;
      $display("FAIL clean_step_latency: head rose after %0d clocks, required 7..10", k_out);
    end
    check_out(4'b1000, "clean_step");
    wait_drain(5, "clean_step");
  endtask

  task automatic test_glitch;
    exp_q.push_back(4'b0000);
    head_bruto = 1'b0;
    wait_drain(30, "head_low");
    head_bruto = 1'b1;
    step(4);
    head_bruto = 1'b0;
    step(20);
    check_out(4'b0000, "glitch_4clk");
    head_bruto = 1'b1;
    step(1);
    head_bruto = 1'b0;
    step(20);
    check_out(4'b0000, "glitch_1clk");
  endtask

  task automatic test_bounce;
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 20; i++) begin
      rubble_bruto = ~rubble_bruto;
      step(1);
    end
    rubble_bruto = 1'b1;
    wait_drain(30, "bounce");
    check_out(4'b0001, "bounce_final");
  endtask

  task automatic test_simultaneous;
    exp_q.push_back(4'b0111);
    left_bruto = 1'b1;
    under_bruto = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(1);
      vectors++;
      if (left !== under) begin
        miscompares++;
        $display("FAIL simultaneous_skew: left=%b under=%b required equal", left, under);
      end
    end
    check_out(4'b0111, "simultaneous");
    wait_drain(5, "simultaneous");
  endtask

  task automatic test_reset_mid;
    int k_out;
    k_out = 0;
    head_bruto = 1'b1;
    step(6);
    reset = 1'b1;
    step(2);
    check_out(4'b0000, "mid_reset_outputs");
    vectors++;
    if (pronto !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_pronto: got %b required 0", pronto);
    end
    exp_q.push_back(4'b1111);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (head === 1'b1 && k_out == 0) k_out = k;
    end
    vectors++;
    if (k_out != 8) begin
      miscompares++;
      $display("FAIL mid_reset_relatency: head rose after %0d clocks, required 8", k_out);
    end
    check_out(4'b1111, "mid_reset_final");
    wait_drain(5, "mid_reset");
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    step(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
